// File: rtl/sram_port_arbiter_if.sv
// Requester-side bundle for sram_port_arbiter: two request/response ports A and B.
// master = requester view, slave = arbiter view.
interface sram_port_arbiter_if #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32
);
   logic                  REQ_VALID_A;
   logic                  REQ_VALID_B;
   logic                  REQ_READY_A;
   logic                  REQ_READY_B;
   logic                  REQ_WE_A;
   logic                  REQ_WE_B;
   logic [ADDR_W-1:0]     REQ_ADDR_A;
   logic [ADDR_W-1:0]     REQ_ADDR_B;
   logic [DATA_W-1:0]     REQ_WDATA_A;
   logic [DATA_W-1:0]     REQ_WDATA_B;
   logic [DATA_W/8-1:0]   REQ_BE_A;
   logic [DATA_W/8-1:0]   REQ_BE_B;
   logic                  RSP_VALID_A;
   logic                  RSP_VALID_B;
   logic [DATA_W-1:0]     RSP_RDATA_A;
   logic [DATA_W-1:0]     RSP_RDATA_B;

   modport master (
      output REQ_VALID_A, REQ_VALID_B, REQ_WE_A, REQ_WE_B,
             REQ_ADDR_A, REQ_ADDR_B, REQ_WDATA_A, REQ_WDATA_B,
             REQ_BE_A, REQ_BE_B,
      input  REQ_READY_A, REQ_READY_B, RSP_VALID_A, RSP_VALID_B,
             RSP_RDATA_A, RSP_RDATA_B
   );

   modport slave (
      input  REQ_VALID_A, REQ_VALID_B, REQ_WE_A, REQ_WE_B,
             REQ_ADDR_A, REQ_ADDR_B, REQ_WDATA_A, REQ_WDATA_B,
             REQ_BE_A, REQ_BE_B,
      output REQ_READY_A, REQ_READY_B, RSP_VALID_A, RSP_VALID_B,
             RSP_RDATA_A, RSP_RDATA_B
   );
endinterface

// File: rtl/sram_port_arbiter.sv
// Two-port round-robin arbiter onto a single-port SRAM macro.
// Accept in N -> SRAM access in N+1 -> response strobe in N+2.
module sram_port_arbiter #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32
) (
   input  logic                CLK,
   input  logic                RST_N,
   input  logic                ENA,
   sram_port_arbiter_if.slave  req,
   output logic [ADDR_W-1:0]   SRAM_ADDR,
   output logic [DATA_W-1:0]   SRAM_DIN,
   output logic [DATA_W-1:0]   SRAM_BM,
   output logic                SRAM_MEN,
   output logic                SRAM_WEN,
   output logic                SRAM_REN,
   input  logic [DATA_W-1:0]   SRAM_DOUT,
   output logic                BUSY
);

   logic                gnt_a;
   logic                gnt_b;
   logic                sel_we;
   logic [ADDR_W-1:0]   sel_addr;
   logic [DATA_W-1:0]   sel_wdata;
   logic [DATA_W/8-1:0] sel_be;

   // last_b_q=1 means B was granted last, so A wins the next tie
   logic                last_b_d,  last_b_q;
   logic                s1_vld_d,  s1_vld_q;
   logic                s1_port_d, s1_port_q;
   logic                s1_we_d,   s1_we_q;
   logic                s2_vld_d,  s2_vld_q;
   logic                s2_port_d, s2_port_q;
   logic                s2_we_d,   s2_we_q;
   logic [ADDR_W-1:0]   addr_d,    addr_q;
   logic [DATA_W-1:0]   din_d,     din_q;
   logic [DATA_W-1:0]   bm_d,      bm_q;
   logic                men_d,     men_q;
   logic                wen_d,     wen_q;
   logic                ren_d,     ren_q;

   always_comb begin
      gnt_a     = RST_N & ENA & req.REQ_VALID_A & (~req.REQ_VALID_B | last_b_q);
      gnt_b     = RST_N & ENA & req.REQ_VALID_B & (~req.REQ_VALID_A | ~last_b_q);
      sel_we    = gnt_b ? req.REQ_WE_B    : req.REQ_WE_A;
      sel_addr  = gnt_b ? req.REQ_ADDR_B  : req.REQ_ADDR_A;
      sel_wdata = gnt_b ? req.REQ_WDATA_B : req.REQ_WDATA_A;
      sel_be    = gnt_b ? req.REQ_BE_B    : req.REQ_BE_A;

      last_b_d  = last_b_q;
      if (gnt_b)
         last_b_d = 1'b1;
      else if (gnt_a)
         last_b_d = 1'b0;

      s1_vld_d  = gnt_a | gnt_b;
      s1_port_d = gnt_b;
      s1_we_d   = sel_we;
      men_d     = s1_vld_d;
      wen_d     = s1_vld_d & sel_we;
      ren_d     = s1_vld_d & ~sel_we;
      addr_d    = s1_vld_d ? sel_addr  : addr_q;
      din_d     = s1_vld_d ? sel_wdata : din_q;
      bm_d      = '0;
      if (s1_vld_d && sel_we) begin
         for (int unsigned k = 0; k < DATA_W/8; k++)
            bm_d[8*k +: 8] = {8{sel_be[k]}};
      end

      s2_vld_d  = s1_vld_q;
      s2_port_d = s1_port_q;
      s2_we_d   = s1_we_q;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         last_b_q  <= 1'b1;
         s1_vld_q  <= 1'b0;
         s1_port_q <= 1'b0;
         s1_we_q   <= 1'b0;
         s2_vld_q  <= 1'b0;
         s2_port_q <= 1'b0;
         s2_we_q   <= 1'b0;
         addr_q    <= '0;
         din_q     <= '0;
         bm_q      <= '0;
         men_q     <= 1'b0;
         wen_q     <= 1'b0;
         ren_q     <= 1'b0;
      end else begin
         last_b_q  <= last_b_d;
         s1_vld_q  <= s1_vld_d;
         s1_port_q <= s1_port_d;
         s1_we_q   <= s1_we_d;
         s2_vld_q  <= s2_vld_d;
         s2_port_q <= s2_port_d;
         s2_we_q   <= s2_we_d;
         addr_q    <= addr_d;
         din_q     <= din_d;
         bm_q      <= bm_d;
         men_q     <= men_d;
         wen_q     <= wen_d;
         ren_q     <= ren_d;
      end
   end

   assign req.REQ_READY_A = gnt_a;
   assign req.REQ_READY_B = gnt_b;

   // SRAM read data arrives the cycle after the access, aligned with the stage-2 strobe
   assign req.RSP_VALID_A = s2_vld_q & ~s2_port_q;
   assign req.RSP_VALID_B = s2_vld_q &  s2_port_q;
   assign req.RSP_RDATA_A = (req.RSP_VALID_A & ~s2_we_q) ? SRAM_DOUT : '0;
   assign req.RSP_RDATA_B = (req.RSP_VALID_B & ~s2_we_q) ? SRAM_DOUT : '0;

   assign SRAM_ADDR = addr_q;
   assign SRAM_DIN  = din_q;
   assign SRAM_BM   = bm_q;
   assign SRAM_MEN  = men_q;
   assign SRAM_WEN  = wen_q;
   assign SRAM_REN  = ren_q;
   assign BUSY      = s1_vld_q | s2_vld_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a behavioural byte-masked SRAM model.
module tb_sram_port_arbiter;

   logic        CLK = 1'b0;
   logic        RST_N;
   logic        ENA;
   logic [9:0]  SRAM_ADDR;
   logic [31:0] SRAM_DIN;
   logic [31:0] SRAM_BM;
   logic        SRAM_MEN;
   logic        SRAM_WEN;
   logic        SRAM_REN;
   logic [31:0] SRAM_DOUT;
   logic        BUSY;
   logic [31:0] mem [0:1023];

   int checks = 0;
   int errors = 0;

   sram_port_arbiter_if #(.ADDR_W(10), .DATA_W(32)) bus ();

   sram_port_arbiter #(.ADDR_W(10), .DATA_W(32)) dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .ENA       (ENA),
      .req       (bus.slave),
      .SRAM_ADDR (SRAM_ADDR),
      .SRAM_DIN  (SRAM_DIN),
      .SRAM_BM   (SRAM_BM),
      .SRAM_MEN  (SRAM_MEN),
      .SRAM_WEN  (SRAM_WEN),
      .SRAM_REN  (SRAM_REN),
      .SRAM_DOUT (SRAM_DOUT),
      .BUSY      (BUSY)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) begin
      if (SRAM_MEN) begin
         if (SRAM_WEN)
            mem[SRAM_ADDR] <= (mem[SRAM_ADDR] & ~SRAM_BM) | (SRAM_DIN & SRAM_BM);
         if (SRAM_REN)
            SRAM_DOUT <= mem[SRAM_ADDR];
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic drive(input logic va, input logic wa, input logic [9:0] aa,
                        input logic [31:0] da, input logic [3:0] ba,
                        input logic vb, input logic wb, input logic [9:0] ab,
                        input logic [31:0] db, input logic [3:0] bb);
      bus.REQ_VALID_A = va;  bus.REQ_WE_A = wa;  bus.REQ_ADDR_A = aa;
      bus.REQ_WDATA_A = da;  bus.REQ_BE_A = ba;
      bus.REQ_VALID_B = vb;  bus.REQ_WE_B = wb;  bus.REQ_ADDR_B = ab;
      bus.REQ_WDATA_B = db;  bus.REQ_BE_B = bb;
      #1;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 10'h0, 32'h0, 4'h0, 1'b0, 1'b0, 10'h0, 32'h0, 4'h0);
   endtask

   initial begin
      RST_N = 1'b0;
      ENA   = 1'b1;
      // reset state, with both requesters asserting valid
      drive(1'b1, 1'b1, 10'h5, 32'h1, 4'hF, 1'b1, 1'b0, 10'h6, 32'h2, 4'hF);
      tick();
      chk("rst_ready_a", bus.REQ_READY_A, 0);
      chk("rst_ready_b", bus.REQ_READY_B, 0);
      chk("rst_men",     SRAM_MEN, 0);
      chk("rst_wen_ren", {SRAM_WEN, SRAM_REN}, 0);
      chk("rst_busy",    BUSY, 0);
      chk("rst_addr",    SRAM_ADDR, 0);
      chk("rst_din_bm",  {SRAM_DIN, SRAM_BM}, 0);
      chk("rst_rsp",     {bus.RSP_VALID_A, bus.RSP_VALID_B}, 0);
      chk("rst_rdata",   {bus.RSP_RDATA_A, bus.RSP_RDATA_B}, 0);
      idle();
      RST_N = 1'b1;
      tick();

      // write A 0x005
      drive(1'b1, 1'b1, 10'h005, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0, 10'h0, 32'h0, 4'h0);
      chk("wa_ready_a", bus.REQ_READY_A, 1);
      chk("wa_ready_b", bus.REQ_READY_B, 0);
      tick(); idle();
      chk("wa_n1_men_wen_ren", {SRAM_MEN, SRAM_WEN, SRAM_REN}, 3'b110);
      chk("wa_n1_bm",   SRAM_BM, 32'hFFFFFFFF);
      chk("wa_n1_addr", SRAM_ADDR, 10'h005);
      chk("wa_n1_din",  SRAM_DIN, 32'hDEADBEEF);
      chk("wa_n1_busy", BUSY, 1);
      chk("wa_n1_rsp",  bus.RSP_VALID_A, 0);
      tick();
      chk("wa_n2_rsp_a",  bus.RSP_VALID_A, 1);
      chk("wa_n2_rdata",  bus.RSP_RDATA_A, 0);
      chk("wa_n2_men_bm", {SRAM_MEN, SRAM_BM}, 0);
      chk("wa_n2_hold",   {SRAM_ADDR, SRAM_DIN}, {10'h005, 32'hDEADBEEF});
      chk("wa_n2_busy",   BUSY, 1);

      // read A 0x005
      drive(1'b1, 1'b0, 10'h005, 32'h0, 4'h0, 1'b0, 1'b0, 10'h0, 32'h0, 4'h0);
      chk("ra_ready_a", bus.REQ_READY_A, 1);
      tick(); idle();
      chk("ra_n1_men_wen_ren", {SRAM_MEN, SRAM_WEN, SRAM_REN}, 3'b101);
      chk("ra_n1_bm",  SRAM_BM, 0);
      tick();
      chk("ra_n2_rsp",   {bus.RSP_VALID_A, bus.RSP_VALID_B}, 2'b10);
      chk("ra_n2_rdata", bus.RSP_RDATA_A, 32'hDEADBEEF);
      tick();
      chk("ra_n3_rsp",   bus.RSP_VALID_A, 0);
      chk("ra_n3_rdata", bus.RSP_RDATA_A, 0);
      chk("ra_n3_busy",  BUSY, 0);

      // B: full write, partial write, read back-to-back on 0x3FF
      drive(1'b0, 1'b0, 10'h0, 32'h0, 4'h0, 1'b1, 1'b1, 10'h3FF, 32'hAABBCCDD, 4'hF);
      chk("wb0_ready_b", bus.REQ_READY_B, 1);
      tick();
      drive(1'b0, 1'b0, 10'h0, 32'h0, 4'h0, 1'b1, 1'b1, 10'h3FF, 32'h11223344, 4'b0101);
      chk("wb1_ready_b", bus.REQ_READY_B, 1);
      chk("wb0_bm",      SRAM_BM, 32'hFFFFFFFF);
      tick();
      drive(1'b0, 1'b0, 10'h0, 32'h0, 4'h0, 1'b1, 1'b0, 10'h3FF, 32'h0, 4'h0);
      chk("rb_ready_b", bus.REQ_READY_B, 1);
      chk("wb1_bm",     SRAM_BM, 32'h00FF00FF);
      chk("wb1_din",    SRAM_DIN, 32'h11223344);
      chk("wb0_rsp",    {bus.RSP_VALID_B, bus.RSP_RDATA_B}, {1'b1, 32'h0});
      tick(); idle();
      chk("rb_n1_ren_bm", {SRAM_REN, SRAM_BM}, {1'b1, 32'h0});
      chk("wb1_rsp",      {bus.RSP_VALID_B, bus.RSP_RDATA_B}, {1'b1, 32'h0});
      tick();
      chk("rb_rsp_b",  {bus.RSP_VALID_A, bus.RSP_VALID_B}, 2'b01);
      chk("rb_rdata",  bus.RSP_RDATA_B, 32'hAA22CC44);
      tick();
      chk("rb_done", bus.RSP_VALID_B, 0);

      // round robin right after a reset
      RST_N = 1'b0; #1; RST_N = 1'b1;
      for (int k = 0; k < 8; k++) begin
         if (k < 6)
            drive(1'b1, 1'b0, 10'h010, 32'h0, 4'h0, 1'b1, 1'b0, 10'h020, 32'h0, 4'h0);
         else
            idle();
         chk($sformatf("rr%0d_ready_a", k), bus.REQ_READY_A, (k < 6) && (k % 2 == 0));
         chk($sformatf("rr%0d_ready_b", k), bus.REQ_READY_B, (k < 6) && (k % 2 == 1));
         if (k >= 1) begin
            chk($sformatf("rr%0d_men", k), SRAM_MEN, (k - 1) < 6);
            if (k - 1 < 6)
               chk($sformatf("rr%0d_addr", k), SRAM_ADDR, ((k - 1) % 2 == 0) ? 10'h010 : 10'h020);
         end
         if (k >= 2) begin
            chk($sformatf("rr%0d_rsp_a", k), bus.RSP_VALID_A, (k - 2) % 2 == 0);
            chk($sformatf("rr%0d_rsp_b", k), bus.RSP_VALID_B, (k - 2) % 2 == 1);
         end
         tick();
      end

      // ENA gating
      ENA = 1'b0;
      drive(1'b1, 1'b0, 10'h005, 32'h0, 4'h0, 1'b1, 1'b0, 10'h3FF, 32'h0, 4'h0);
      chk("ena0_ready", {bus.REQ_READY_A, bus.REQ_READY_B}, 2'b00);
      tick();
      chk("ena0_men", SRAM_MEN, 0);
      ENA = 1'b1;
      drive(1'b1, 1'b0, 10'h005, 32'h0, 4'h0, 1'b0, 1'b0, 10'h0, 32'h0, 4'h0);
      chk("ena1_ready_a", bus.REQ_READY_A, 1);
      tick();
      ENA = 1'b0; #1;
      chk("enadrop_ready_a", bus.REQ_READY_A, 0);
      chk("enadrop_men",     SRAM_MEN, 1);
      tick();
      chk("enadrop_rsp_a", bus.RSP_VALID_A, 1);
      chk("enadrop_rdata", bus.RSP_RDATA_A, 32'hDEADBEEF);
      chk("enadrop_men2",  SRAM_MEN, 0);
      ENA = 1'b1;
      idle();
      tick();

      // reset during N+1 of a read discards it
      drive(1'b1, 1'b0, 10'h005, 32'h0, 4'h0, 1'b0, 1'b0, 10'h0, 32'h0, 4'h0);
      chk("mr_ready_a", bus.REQ_READY_A, 1);
      tick();
      chk("mr_n1_men_ren", {SRAM_MEN, SRAM_REN}, 2'b11);
      RST_N = 1'b0; #1;
      chk("mr_ready_a_low", bus.REQ_READY_A, 0);
      chk("mr_sram_ctl", {SRAM_MEN, SRAM_WEN, SRAM_REN, BUSY}, 0);
      chk("mr_sram_bus", {SRAM_ADDR, SRAM_DIN, SRAM_BM}, 0);
      chk("mr_rsp",      {bus.RSP_VALID_A, bus.RSP_VALID_B, bus.RSP_RDATA_A}, 0);
      idle();
      tick();
      RST_N = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk($sformatf("mr_post%0d_rsp", k), {bus.RSP_VALID_A, bus.RSP_VALID_B, BUSY}, 0);
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
